// File: rtl/fft_pkg.sv
// Shared sizes and types for the FFT spectrum column binner.
// Frame-end events travel down a short pipe so the swap lines up with the last column write.
package fft_pkg;
   localparam int FFT_POINTS   = 1024;
   localparam int IDX_W        = 10;
   localparam int SAMPLE_W     = 16;
   localparam int N_COLS       = 32;
   localparam int BINS_PER_COL = 16;
   localparam int HEIGHT_W     = 5;
   localparam int HEIGHT_MAX   = 16;
   localparam int ACC_W        = 36;
   localparam int COL_W        = $clog2(N_COLS);

   typedef enum logic [1:0] {
      FRAME_IDLE,
      FRAME_RUN,
      FRAME_BAD
   } frame_state_e;

   typedef struct packed {
      logic valid;
      logic good;
   } frame_evt_t;
endpackage

// File: rtl/spectrum_log_height.sv
// Maps a column energy sum to a log2 LED height: leading-one position relative to FLOOR_BIT,
// clamped to the matrix height.
module spectrum_log_height
   import fft_pkg::*;
#(
   parameter int FLOOR_BIT = 16
) (
   input  logic [ACC_W-1:0]    acc_i,
   output logic [HEIGHT_W-1:0] height_o
);

   int msb;
   int span;

   always_comb begin
      msb = -1;
      for (int i = 0; i < ACC_W; i++) begin
         if (acc_i[i]) msb = i;
      end
      span     = msb - FLOOR_BIT + 1;
      height_o = '0;
      if (msb >= FLOOR_BIT) begin
         height_o = (span >= HEIGHT_MAX) ? HEIGHT_W'(HEIGHT_MAX) : HEIGHT_W'(span);
      end
   end

endmodule

// File: rtl/spectrum_column_binner.sv
// Turns xfft frames into 32 LED column heights: square/sum/accumulate pipeline, frame checker,
// and a working/published pair of height register files so the display never sees a partial frame.
module spectrum_column_binner
   import fft_pkg::*;
#(
   parameter int BIN_BASE   = 0,
   parameter int FLOOR_BIT  = 16,
   parameter int DECAY_STEP = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                s_tvalid,
   input  logic                s_tlast,
   input  logic [31:0]         s_tdata,
   input  logic [IDX_W-1:0]    s_tuser,
   input  logic [COL_W-1:0]    rd_col,
   output logic [HEIGHT_W-1:0] rd_height,
   output logic                frame_done,
   output logic                frame_err
);

   localparam logic [IDX_W:0]   WIN_LO   = (IDX_W+1)'(BIN_BASE);
   localparam logic [IDX_W:0]   WIN_HI   = (IDX_W+1)'(BIN_BASE + N_COLS*BINS_PER_COL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS-1);

   frame_state_e     state_q, state_d;
   logic [IDX_W-1:0] expIdx_q, expIdx_d;
   logic             beatOk, idxMatch, lastOk, inWin;
   frame_evt_t       endEvt;
   frame_evt_t [4:0] evt_q;

   logic [COL_W+3:0] binRel;
   logic [30:0]      reSq, imSq;
   logic [31:0]      reExt, imExt;

   logic             v1_q, v2_q, wr3_q;
   logic             first1_q, last1_q, first2_q, last2_q;
   logic [COL_W-1:0] col1_q, col2_q, col3_q;
   logic [30:0]      reSq1_q, imSq1_q;
   logic [31:0]      mag2_q;
   logic [ACC_W-1:0] acc_q;

   logic [HEIGHT_W-1:0] work_q [N_COLS];
   logic [HEIGHT_W-1:0] pub_q  [N_COLS];
   logic [HEIGHT_W-1:0] newHeight, decayed, stored, pubCol;
   logic                swap;

   // Frame checker: a beat only feeds the arithmetic while the frame is still clean.
   // Outside a frame, stray beats are dropped until one with index 0 arrives.
   always_comb begin
      state_d  = state_q;
      expIdx_d = expIdx_q;
      beatOk   = 1'b0;
      endEvt   = '0;
      idxMatch = (s_tuser == expIdx_q);
      lastOk   = (s_tlast == (s_tuser == LAST_IDX));
      if (s_tvalid) begin
         unique case (state_q)
            FRAME_IDLE, FRAME_RUN: begin
               if (state_q == FRAME_RUN || s_tuser == '0) begin
                  beatOk   = idxMatch && lastOk;
                  expIdx_d = expIdx_q + 1'b1;
                  state_d  = beatOk ? FRAME_RUN : FRAME_BAD;
                  if (s_tlast) begin
                     endEvt.valid = 1'b1;
                     endEvt.good  = beatOk;
                     state_d      = FRAME_IDLE;
                     expIdx_d     = '0;
                  end
               end
            end
            FRAME_BAD: begin
               expIdx_d = expIdx_q + 1'b1;
               if (s_tlast) begin
                  endEvt.valid = 1'b1;
                  state_d      = FRAME_IDLE;
                  expIdx_d     = '0;
               end
            end
            default: state_d = FRAME_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= FRAME_IDLE;
         expIdx_q <= '0;
         evt_q    <= '0;
      end else begin
         state_q  <= state_d;
         expIdx_q <= expIdx_d;
         evt_q    <= {evt_q[3:0], endEvt};
      end
   end

   assign inWin  = ({1'b0, s_tuser} >= WIN_LO) && ({1'b0, s_tuser} < WIN_HI);
   assign binRel = (COL_W+4)'(s_tuser - WIN_LO[IDX_W-1:0]);
   assign reExt  = {{(32-SAMPLE_W){s_tdata[SAMPLE_W-1]}}, s_tdata[SAMPLE_W-1:0]};
   assign imExt  = {{(32-SAMPLE_W){s_tdata[31]}}, s_tdata[31:SAMPLE_W]};
   assign reSq   = 31'(reExt * reExt);
   assign imSq   = 31'(imExt * imExt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         wr3_q    <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         first2_q <= 1'b0;
         last2_q  <= 1'b0;
         col1_q   <= '0;
         col2_q   <= '0;
         col3_q   <= '0;
         reSq1_q  <= '0;
         imSq1_q  <= '0;
         mag2_q   <= '0;
         acc_q    <= '0;
      end else begin
         v1_q     <= beatOk && inWin;
         col1_q   <= binRel[COL_W+3:4];
         first1_q <= (binRel[3:0] == 4'd0);
         last1_q  <= (binRel[3:0] == 4'(BINS_PER_COL-1));
         reSq1_q  <= reSq;
         imSq1_q  <= imSq;
         v2_q     <= v1_q;
         col2_q   <= col1_q;
         first2_q <= first1_q;
         last2_q  <= last1_q;
         mag2_q   <= {1'b0, reSq1_q} + {1'b0, imSq1_q};
         if (v2_q) begin
            acc_q <= first2_q ? {4'd0, mag2_q} : acc_q + {4'd0, mag2_q};
         end
         wr3_q  <= v2_q && last2_q;
         col3_q <= col2_q;
      end
   end

   spectrum_log_height #(
      .FLOOR_BIT(FLOOR_BIT)
   ) u_logHeight (
      .acc_i   (acc_q),
      .height_o(newHeight)
   );

   // A quiet column falls at most DECAY_STEP rows per published frame.
   always_comb begin
      pubCol  = pub_q[col3_q];
      decayed = (int'(pubCol) > DECAY_STEP) ? HEIGHT_W'(int'(pubCol) - DECAY_STEP) : '0;
      stored  = (newHeight > decayed) ? newHeight : decayed;
   end

   assign swap = evt_q[4].valid && evt_q[4].good;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_COLS; i++) work_q[i] <= '0;
      end else if (wr3_q) begin
         work_q[col3_q] <= stored;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_COLS; i++) pub_q[i] <= '0;
         rd_height  <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (swap) begin
            for (int i = 0; i < N_COLS; i++) pub_q[i] <= work_q[i];
         end
         rd_height  <= pub_q[rd_col];
         frame_done <= swap;
         frame_err  <= evt_q[4].valid && !evt_q[4].good;
      end
   end

endmodule

// File: tb/tb_spectrum_column_binner.sv
// Randomized bench for spectrum_column_binner; expected heights come from a per-frame
// energy model computed straight from the bin samples.
module tb_spectrum_column_binner;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        s_tvalid;
   logic        s_tlast;
   logic [31:0] s_tdata;
   logic [9:0]  s_tuser;
   logic [4:0]  rd_col;
   logic [4:0]  rd_height;
   logic        frame_done;
   logic        frame_err;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int doneCount = 0;
   int errCount = 0;
   int lastDoneCycle = 0;
   int prevDoneCycle = 0;
   int tlastEdge = 0;

   logic signed [15:0] reArr [1024];
   logic signed [15:0] imArr [1024];
   int pubModel [32];

   spectrum_column_binner dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_tvalid  (s_tvalid),
      .s_tlast   (s_tlast),
      .s_tdata   (s_tdata),
      .s_tuser   (s_tuser),
      .rd_col    (rd_col),
      .rd_height (rd_height),
      .frame_done(frame_done),
      .frame_err (frame_err)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Pulse counters sampled mid-cycle; a pulse wider than one cycle counts more than once.
   always @(negedge clk) begin
      if (frame_done) begin
         doneCount++;
         prevDoneCycle = lastDoneCycle;
         lastDoneCycle = cycle;
      end
      if (frame_err) errCount++;
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0: good frame, 1: tlast on beat 500, 2: index 7 sent twice.
   // stopAt >= 0 stops after that beat without tlast.
   task automatic applyStimulus(input int mode, input bit gaps, input int stopAt);
      int seq[$];
      seq = {};
      if (mode == 1) begin
         for (int i = 0; i <= 500; i++) seq.push_back(i);
      end else begin
         for (int i = 0; i < 1024; i++) begin
            seq.push_back(i);
            if (mode == 2 && i == 7) seq.push_back(7);
         end
      end
      if (stopAt >= 0) seq = seq[0:stopAt];
      for (int k = 0; k < seq.size(); k++) begin
         if (gaps) begin
            for (int g = 0; g < 4; g++) begin
               if ($urandom_range(1, 0) == 0) break;
               s_tvalid = 1'b0;
               s_tlast  = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_tvalid = 1'b1;
         s_tuser  = 10'(seq[k]);
         s_tdata  = {imArr[seq[k]], reArr[seq[k]]};
         s_tlast  = (stopAt < 0) && (k == seq.size() - 1);
         if (s_tlast) tlastEdge = cycle + 1;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   function automatic int heightOf(input longint sum);
      logic [63:0] v;
      int m;
      v = sum;
      if (v == 0) return 0;
      m = 0;
      for (int b = 0; b < 64; b++) if (v[b]) m = b;
      if (m < 16) return 0;
      return (m - 15 > 16) ? 16 : m - 15;
   endfunction

   function automatic void modelGoodFrame();
      for (int c = 0; c < 32; c++) begin
         longint sum;
         int h, dec;
         sum = 0;
         for (int b = 0; b < 16; b++) begin
            sum += longint'(reArr[c*16+b]) * longint'(reArr[c*16+b])
                 + longint'(imArr[c*16+b]) * longint'(imArr[c*16+b]);
         end
         h   = heightOf(sum);
         dec = pubModel[c] - 1;
         if (dec < 0) dec = 0;
         pubModel[c] = (h > dec) ? h : dec;
      end
   endfunction

   function automatic logic signed [15:0] randVal(input int sc);
      int v;
      v = int'($urandom_range((1 << sc) - 1, 0));
      if ($urandom_range(1, 0) == 1) v = -v;
      return 16'(v);
   endfunction

   function automatic void fillConst(input logic signed [15:0] re, input logic signed [15:0] im);
      for (int i = 0; i < 1024; i++) begin
         reArr[i] = re;
         imArr[i] = im;
      end
   endfunction

   function automatic void fillRandom();
      for (int c = 0; c < 64; c++) begin
         int sc;
         sc = $urandom_range(15, 1);
         for (int b = 0; b < 16; b++) begin
            reArr[c*16+b] = (sc == 1) ? 16'sd0 : randVal(sc);
            imArr[c*16+b] = (sc == 1) ? 16'sd0 : randVal(sc);
         end
      end
   endfunction

   task automatic readCol(input int c, output int h);
      rd_col = 5'(c);
      @(posedge clk);
      #1;
      h = int'(rd_height);
   endtask

   task automatic readAll(input string tag);
      int h;
      for (int c = 0; c < 32; c++) begin
         readCol(c, h);
         checkOutput($sformatf("%s col%0d", tag, c), h, pubModel[c]);
      end
   endtask

   task automatic goodFrame(input string tag, input bit gaps);
      int d0, e0;
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(0, gaps, -1);
      idle(12);
      modelGoodFrame();
      checkOutput({tag, " done"}, doneCount - d0, 1);
      checkOutput({tag, " err"}, errCount - e0, 0);
   endtask

   task automatic badFrame(input string tag, input int mode);
      int d0, e0;
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(mode, 1'b1, -1);
      idle(12);
      checkOutput({tag, " done"}, doneCount - d0, 0);
      checkOutput({tag, " err"}, errCount - e0, 1);
      readAll(tag);
   endtask

   initial begin
      int h, d0;
      reset_n  = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      s_tuser  = '0;
      rd_col   = '0;
      for (int c = 0; c < 32; c++) pubModel[c] = 0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset frame_done", frame_done, 0);
      checkOutput("reset frame_err", frame_err, 0);
      reset_n = 1'b1;
      idle(2);
      readAll("reset");

      fillConst(16'sd0, 16'sd0);
      reArr[40] = 16'sd16384;
      goodFrame("tone", 1'b0);
      checkOutput("tone latency", lastDoneCycle - tlastEdge, 5);
      readAll("tone");
      readCol(2, h);
      checkOutput("tone col2", h, 13);

      fillConst(16'sd0, 16'sd0);
      for (int k = 0; k < 14; k++) begin
         goodFrame("decay", 1'b0);
         readCol(2, h);
         checkOutput($sformatf("decay col2 frame%0d", k), h, (12 - k > 0) ? 12 - k : 0);
      end
      readAll("decay");

      fillConst(-16'sd32768, -16'sd32768);
      goodFrame("fullscale", 1'b0);
      readAll("fullscale");
      readCol(7, h);
      checkOutput("fullscale col7", h, 16);
      goodFrame("fullscale gaps", 1'b1);
      readAll("fullscale gaps");

      fillRandom();
      badFrame("early tlast", 1);
      badFrame("dup idx7", 2);
      goodFrame("after bad", 1'b0);
      readAll("after bad");

      for (int r = 0; r < 3; r++) begin
         fillRandom();
         goodFrame($sformatf("random%0d", r), 1'b1);
         readAll($sformatf("random%0d", r));
      end

      fillRandom();
      applyStimulus(0, 1'b0, 300);
      reset_n = 1'b0;
      idle(3);
      checkOutput("midreset rd_height", rd_height, 0);
      reset_n = 1'b1;
      for (int c = 0; c < 32; c++) pubModel[c] = 0;
      idle(2);
      readAll("midreset");

      d0 = doneCount;
      fillRandom();
      applyStimulus(0, 1'b0, -1);
      modelGoodFrame();
      fillRandom();
      applyStimulus(0, 1'b0, -1);
      modelGoodFrame();
      idle(12);
      checkOutput("b2b done count", doneCount - d0, 2);
      checkOutput("b2b spacing", lastDoneCycle - prevDoneCycle, 1024);
      readAll("b2b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
